// File: rtl/net_pkg.sv
// Shared types and defaults for the RMII transmit scheduler.
// Holds the scheduler state encoding and default gap/timeout lengths.
package net_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_DONE,
        S_GAP
    } txs_state_t;

    localparam int GAP_CYC_DEF     = 48;
    localparam int TIMEOUT_CYC_DEF = 100000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, cyclic.
// Ports: req, ptr in; gnt (one-hot), idx (winner index), valid out.
module rr_arbiter
    import net_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // ptr + i wrapped into 0..N-1 (works for non power-of-two N)
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/net_tx_scheduler.sv
// Shares one RMII transmit engine among N_REQ requesters: round-robin grant,
// one frame in flight, timeout tracking and a minimum inter-frame gap.
// Ports: clk, rst (async active-low), ready, req, tx_done in;
//        grant, src_id, trg, busy, timeout_err, frames_sent out (all registered).
module net_tx_scheduler
    import net_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] src_id,
    output logic                     trg,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [CNT_W-1:0]         frames_sent
);

    localparam int IW      = $clog2(N_REQ);
    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    txs_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    win_q;
    logic [N_REQ-1:0] win_oh_q;
    logic [TW-1:0]    cnt;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            win_q       <= '0;
            win_oh_q    <= '0;
            cnt         <= '0;
            grant       <= '0;
            src_id      <= '0;
            trg         <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            frames_sent <= '0;
        end else begin
            trg   <= 1'b0;
            grant <= '0;
            if (!ready) begin
                // link lost: abandon any frame, keep pointer and stats
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (arb_valid) begin
                            win_q    <= arb_idx;
                            win_oh_q <= arb_gnt;
                            state    <= S_FIRE;
                        end
                    end
                    S_FIRE: begin
                        trg    <= 1'b1;
                        grant  <= win_oh_q;
                        src_id <= win_q;
                        busy   <= 1'b1;
                        ptr    <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                        cnt    <= '0;
                        state  <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        if (tx_done) begin
                            frames_sent <= frames_sent + 1'b1;
                            cnt         <= '0;
                            state       <= S_GAP;
                        end else if (cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            cnt         <= '0;
                            state       <= S_GAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_net_tx_scheduler.sv
// Scoreboard bench for net_tx_scheduler with a small transmitter model.
// Expected grants are queued by the stimulus and checked by a monitor.
module tb_net_tx_scheduler;

    localparam int N  = 4;
    localparam int G  = 8;
    localparam int T  = 300;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [1:0]    src_id;
    logic          trg;
    logic          tx_done;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] frames_sent;

    net_tx_scheduler #(
        .N_REQ       (N),
        .GAP_CYC     (G),
        .TIMEOUT_CYC (T),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .req         (req),
        .grant       (grant),
        .src_id      (src_id),
        .trg         (trg),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frames_sent (frames_sent)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        int           id;
        int           c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dly = 0;
    bit   auto_clr = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && (trg || grant != '0)) begin
            chk("trg_eq_or_grant", 32'(trg), 32'(|grant));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (trg) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_trg: grant %b at cycle %0d", grant, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("grant", 32'(grant), 32'(e.g));
                    chk("src_id", 32'(src_id), 32'(e.id));
                    if (e.c >= 0) chk("trg_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    // transmitter model: tx_done dly cycles after trg
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trg && dly > 0) begin
                int d;
                d = dly;
                repeat (d) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // requesters drop their line once granted
    initial begin
        forever begin
            logic [N-1:0] g;
            @(negedge clk);
            g = grant;
            if (g != '0) begin
                @(posedge clk);
                #1;
                if (auto_clr) req = req & ~g;
            end
        end
    end

    function automatic exp_t mk(logic [N-1:0] g, int id, int c);
        exp_t e;
        e.g  = g;
        e.id = id;
        e.c  = c;
        return e;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst   = 1'b0;
        ready = 1'b0;
        req   = '0;
        dly   = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_trg(int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (trg) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            errors++;
            checks++;
            $display("FAIL trg_timeout: no trg within %0d cycles", bound);
            c = cyc;
        end
    endtask

    task automatic wait_idle(int bound);
        int ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: busy still high after %0d cycles", bound);
        end
    endtask

    task automatic wait_cyc(int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int n;
        int c;
        int m;
        rst   = 1'b0;
        ready = 1'b0;
        req   = '0;

        // reset values
        do_reset();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_trg", 32'(trg), 0);
        chk("rst_src_id", 32'(src_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_frames", 32'(frames_sent), 0);

        // 1: single requester, 200-cycle frame, gap before next
        @(posedge clk);
        #2;
        n = cyc;
        ready = 1'b1;
        req = 4'b0001;
        dly = 200;
        q.push_back(mk(4'b0001, 0, n + 2));
        wait_trg(10, c);
        chk("t1_busy_trg", 32'(busy), 1);
        @(posedge clk);
        #2;
        dly = 10;
        req = req | 4'b0001;
        q.push_back(mk(4'b0001, 0, c + 211));
        wait_cyc(c + 208);
        chk("t1_busy_end", 32'(busy), 1);
        @(negedge clk);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_frames", 32'(frames_sent), 1);
        wait_trg(20, c);
        wait_idle(100);
        chk("t1_frames2", 32'(frames_sent), 2);

        // 2: all requesting, round-robin order
        do_reset();
        @(posedge clk);
        #2;
        n = cyc;
        auto_clr = 1'b0;
        ready = 1'b1;
        req = 4'b1111;
        dly = 10;
        q.push_back(mk(4'b0001, 0, n + 2));
        q.push_back(mk(4'b0010, 1, n + 23));
        q.push_back(mk(4'b0100, 2, n + 44));
        q.push_back(mk(4'b1000, 3, n + 65));
        q.push_back(mk(4'b0001, 0, n + 86));
        for (int k = 0; k < 5; k++) wait_trg(40, c);
        @(posedge clk);
        #2;
        req = '0;
        auto_clr = 1'b1;
        wait_idle(100);
        chk("t2_frames", 32'(frames_sent), 5);

        // 3: timeout, then a pending request served after the gap
        @(posedge clk);
        #2;
        n = cyc;
        dly = 0;
        req = 4'b0010;
        q.push_back(mk(4'b0010, 1, n + 2));
        wait_trg(10, c);
        @(posedge clk);
        #2;
        req = req | 4'b0100;
        q.push_back(mk(4'b0100, 2, c + T + 10));
        wait_cyc(c + T - 1);
        chk("t3_tout_before", 32'(timeout_err), 0);
        @(negedge clk);
        chk("t3_tout_set", 32'(timeout_err), 1);
        chk("t3_frames", 32'(frames_sent), 5);
        @(posedge clk);
        #2 dly = 10;
        wait_trg(20, c);
        wait_idle(100);
        chk("t3_frames2", 32'(frames_sent), 6);

        // 4: ready dropped mid-frame
        @(posedge clk);
        #2;
        n = cyc;
        dly = 0;
        req = 4'b1000;
        q.push_back(mk(4'b1000, 3, n + 2));
        wait_trg(10, c);
        wait_cyc(c + 5);
        @(posedge clk);
        #2;
        ready = 1'b0;
        req = req | 4'b0011;
        @(negedge clk);
        chk("t4_busy_hold", 32'(busy), 1);
        @(negedge clk);
        chk("t4_busy_drop", 32'(busy), 0);
        chk("t4_frames", 32'(frames_sent), 6);
        repeat (10) @(posedge clk);
        #2;
        m = cyc;
        ready = 1'b1;
        dly = 10;
        q.push_back(mk(4'b0001, 0, m + 2));
        q.push_back(mk(4'b0010, 1, m + 23));
        wait_trg(10, c);
        wait_trg(40, c);
        wait_idle(100);
        chk("t4_frames2", 32'(frames_sent), 8);
        chk("t4_tout_sticky", 32'(timeout_err), 1);

        // 5: tx_done on the timeout cycle wins; stray tx_done ignored
        do_reset();
        @(posedge clk);
        #2;
        n = cyc;
        ready = 1'b1;
        dly = T - 1;
        req = 4'b0100;
        q.push_back(mk(4'b0100, 2, n + 2));
        wait_trg(10, c);
        wait_cyc(c + T);
        chk("t5_frames", 32'(frames_sent), 1);
        chk("t5_tout", 32'(timeout_err), 0);
        @(negedge clk);
        chk("t5_tout_after", 32'(timeout_err), 0);
        chk("t5_busy_gap", 32'(busy), 1);
        wait_idle(100);
        @(posedge clk);
        #2 tx_done = 1'b1;
        @(posedge clk);
        #2 tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_stray_frames", 32'(frames_sent), 1);
        chk("t5_stray_busy", 32'(busy), 0);

        // 6: frames_sent wraps
        @(posedge clk);
        #2;
        auto_clr = 1'b0;
        dly = 2;
        req = 4'b0001;
        for (int k = 0; k < 15; k++) q.push_back(mk(4'b0001, 0, -1));
        for (int k = 1; k <= 15; k++) begin
            wait_trg(40, c);
            wait_cyc(c + 4);
            chk("t6_frames", 32'(frames_sent), 32'((1 + k) % 16));
            if (k == 15) req = '0;
        end
        wait_idle(100);
        auto_clr = 1'b1;

        chk("sb_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
